// File: rtl/trng_fifo_ctrl.sv
// Entropy FIFO sequencer: packs raw bits into 64-bit words on the write side,
// and splits each popped word into two 32-bit valid/ready beats on the read side.
module trng_fifo_ctrl #(
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              fifo_wr_en,
  output logic [63:0]       fifo_din,
  input  logic              fifo_full,
  output logic              fifo_rd_en,
  input  logic [63:0]       fifo_dout,
  input  logic              fifo_empty,
  output logic [31:0]       m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HI, LO} state_t;

  state_t      state;
  logic [62:0] sh;
  logic [5:0]  bit_cnt;
  logic [31:0] hold_lo;
  logic [63:0] word;

  // Candidate word including the bit being accepted this cycle; first bit lands in the MSB.
  assign word = {sh, bit_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh         <= '0;
      bit_cnt    <= '0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      drop_cnt   <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      if (!enable) begin
        sh      <= '0;
        bit_cnt <= '0;
      end else if (bit_valid) begin
        sh      <= word[62:0];
        bit_cnt <= bit_cnt + 6'd1;
        if (bit_cnt == 6'd63) begin
          if (!fifo_full) begin
            fifo_wr_en <= 1'b1;
            fifo_din   <= word;
          end else if (drop_cnt != {DROP_W{1'b1}}) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
          end
        end
      end
    end
  end

  // The upper half goes straight into m_data on leaving WAIT, so only the lower half is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fifo_rd_en <= 1'b0;
      hold_lo    <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state      <= REQ;
            fifo_rd_en <= 1'b1;
          end
        end
        REQ: begin
          fifo_rd_en <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          hold_lo <= fifo_dout[31:0];
          m_data  <= fifo_dout[63:32];
          m_valid <= 1'b1;
          state   <= HI;
        end
        HI: begin
          if (m_ready) begin
            m_data <= hold_lo;
            state  <= LO;
          end
        end
        LO: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (!fifo_empty) begin
              state      <= REQ;
              fifo_rd_en <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          fifo_rd_en <= 1'b0;
          m_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trng_fifo_ctrl.sv
// Bench for trng_fifo_ctrl: a 16-deep FIFO model, a word-level reference model
// feeding expected writes/beats into queues, and negedge monitors that pop and compare.
module tb_trng_fifo_ctrl;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        fifo_wr_en;
  logic [63:0] fifo_din;
  logic        fifo_full;
  logic        fifo_rd_en;
  logic [63:0] fifo_dout;
  logic        fifo_empty;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int rd_seen = 0;

  logic [63:0] exp_wr[$];
  logic [31:0] exp_beat[$];
  logic [63:0] ref_word;
  int          ref_n;
  int          exp_drop;

  logic        prev_stall;
  logic [31:0] prev_data;

  logic [63:0] fq[$];

  trng_fifo_ctrl #(.DROP_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bit_in(bit_in), .bit_valid(bit_valid),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: flags and read data update only at clock edges.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
    end else begin
      int sz;
      sz = fq.size();
      if (fifo_rd_en && sz > 0) fifo_dout <= fq.pop_front();
      if (fifo_wr_en && sz < DEPTH) fq.push_back(fifo_din);
      fifo_full  <= (fq.size() == DEPTH);
      fifo_empty <= (fq.size() == 0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a beat.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", 64'(m_data), 64'(prev_data));
      end
      if (fifo_wr_en) begin
        wr_seen++;
        if (exp_wr.size() == 0) fail("unexpected_write");
        else chk("fifo_din", fifo_din, exp_wr.pop_front());
        $display("write %h", fifo_din);
      end
      if (fifo_rd_en) begin
        rd_seen++;
        chk("rd_en_during_beat", 64'(m_valid), 64'd0);
      end
      if (m_valid && m_ready) begin
        if (exp_beat.size() == 0) fail("unexpected_beat");
        else chk("beat", 64'(m_data), 64'(exp_beat.pop_front()));
        $display("beat %h", m_data);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // Reference: count accepted bits; every 64th completes a word, kept unless the FIFO reads full.
  task automatic drive(input logic en, input logic v, input logic b);
    enable = en; bit_valid = v; bit_in = b;
    if (!en) begin
      ref_n = 0; ref_word = '0;
    end else if (v) begin
      ref_word = {ref_word[62:0], b};
      ref_n++;
      if (ref_n == 64) begin
        ref_n = 0;
        if (!fifo_full) begin
          exp_wr.push_back(ref_word);
          exp_beat.push_back(ref_word[63:32]);
          exp_beat.push_back(ref_word[31:0]);
        end else if (exp_drop < 65535) begin
          exp_drop++;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = 63; i >= 0; i--) drive(1'b1, 1'b1, w[i]);
    drive(1'b1, 1'b0, 1'b0);
  endtask

  task automatic wait_valid();
    int i = 0;
    while (!m_valid && i < 200) begin drive(1'b1, 1'b0, 1'b0); i++; end
    if (!m_valid) fail("wait_valid_timeout");
  endtask

  task automatic drain();
    int i = 0;
    m_ready = 1'b1;
    while ((exp_beat.size() != 0 || exp_wr.size() != 0) && i < 3000) begin
      drive(1'b1, 1'b0, 1'b0); i++;
    end
    if (exp_beat.size() != 0 || exp_wr.size() != 0) fail("drain_timeout");
    repeat (4) drive(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_wr.delete(); exp_beat.delete();
    ref_n = 0; ref_word = '0; exp_drop = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int w0, r0, pct;
    logic [63:0] t1w;
    t1w = 64'h0123_4567_89AB_CDEF;
    rst = 1'b0;
    #1 rst = 1'b1;
    ref_n = 0; ref_word = '0; exp_drop = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_din", fifo_din, 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;

    // T1 bit order
    m_ready = 1'b1; w0 = wr_seen;
    send_word(t1w);
    drain();
    chk("t1_writes", 64'(wr_seen - w0), 64'd1);
    chk("t1_drop", 64'(drop_cnt), 64'd0);

    // T2 backpressure in HI
    m_ready = 1'b0; r0 = rd_seen;
    send_word(t1w);
    wait_valid();
    repeat (10) drive(1'b1, 1'b0, 1'b0);
    chk("t2_hi_data", 64'(m_data), 64'h0123_4567);
    drain();
    chk("t2_reads", 64'(rd_seen - r0), 64'd1);

    // T3 overflow
    m_ready = 1'b0; w0 = wr_seen;
    for (int k = 1; k <= 19; k++) send_word({$urandom, $urandom});
    chk("t3_writes", 64'(wr_seen - w0), 64'd17);
    chk("t3_drop", 64'(drop_cnt), 64'd2);
    chk("t3_drop_model", 64'(drop_cnt), 64'(exp_drop));
    drain();

    // T5 reset while LO is presenting
    m_ready = 1'b0;
    send_word({$urandom, $urandom});
    wait_valid();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("t5_lo_valid", 64'(m_valid), 64'd1);
    #2 rst = 1'b1;
    exp_wr.delete(); exp_beat.delete();
    ref_n = 0; ref_word = '0; exp_drop = 0;
    #1;
    chk("t5_m_valid", 64'(m_valid), 64'd0);
    chk("t5_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("t5_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("t5_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    m_ready = 1'b1; w0 = wr_seen;
    send_word(t1w);
    drain();
    chk("t5_t1_writes", 64'(wr_seen - w0), 64'd1);

    // T4 enable drop discards a partial word
    w0 = wr_seen;
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, 1'($urandom));
    drive(1'b0, 1'b1, 1'b1);
    send_word(64'hFFFF_FFFF_0000_0000);
    drain();
    chk("t4_writes", 64'(wr_seen - w0), 64'd1);

    // T6 back-to-back words
    m_ready = 1'b1; r0 = rd_seen;
    for (int k = 0; k < 3; k++) send_word({$urandom, $urandom});
    drain();
    chk("t6_reads", 64'(rd_seen - r0), 64'd3);

    // Randomized: bursty bits, occasional enable drops, slow and fast consumers
    for (int seg = 0; seg < 2; seg++) begin
      pct = (seg == 0) ? 1 : 60;
      for (int c = 0; c < 2500; c++) begin
        m_ready = ($urandom_range(0, 99) < pct);
        drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 8), 1'($urandom));
      end
      drain();
      chk("rand_drop", 64'(drop_cnt), 64'(exp_drop));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
